instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch_pc_reg.sv | 28 ++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: reset PC, PC stride,
// FSM state encodings and an address-alignment helper.
package instr_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle: redirect input, instruction-memory port and
// decode-stage handshake. master = fetch stage, slave = its environment.
interface instr_fetch_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instruction, pc_out, pc_plus4
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instruction, pc_out, pc_plus4
    );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: asynchronous reset to RESET_PC, load has priority over
// increment, wraps modulo 2^32.
module pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + PC_INCR;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: issues word-aligned reads, holds one fetched
// instruction for decode, and squashes in-flight fetches on redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    logic [1:0]  state;
    logic [31:0] req_addr;
    logic [31:0] pc;
    logic [31:0] target;
    logic        pc_load;
    logic        pc_inc;
    logic        instr_valid_q;
    logic [31:0] instruction_q;
    logic [31:0] pc_out_q;

    assign target = word_align(bus.redirect_pc);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state)
            FETCH: begin
                if (bus.redirect_valid) pc_load = 1'b1;
                else if (bus.imem_ack)  pc_inc  = 1'b1;
            end
            HOLD, FLUSH: pc_load = bus.redirect_valid;
            default: ;
        endcase
    end

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .inc     (pc_inc),
        .load_pc (target),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            req_addr      <= RESET_PC;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            pc_out_q      <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.redirect_valid) begin
                        // An ack in the same cycle retires the old request,
                        // so the target can be issued immediately.
                        if (bus.imem_ack) req_addr <= target;
                        else              state    <= FLUSH;
                    end else if (bus.imem_ack) begin
                        instruction_q <= bus.imem_rdata;
                        pc_out_q      <= req_addr;
                        instr_valid_q <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        instr_valid_q <= 1'b0;
                        req_addr      <= target;
                        state         <= FETCH;
                    end else if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        req_addr      <= pc;
                        state         <= FETCH;
                    end
                end
                FLUSH: begin
                    // Stale data is dropped; the latest redirect target wins.
                    if (bus.imem_ack) begin
                        req_addr <= bus.redirect_valid ? target : pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    instr_valid_q <= 1'b0;
                    state         <= FETCH;
                end
            endcase
        end
    end

    // The request is gated by rst_n so it drops as soon as reset asserts.
    assign bus.imem_req    = rst_n && ((state == FETCH) || (state == FLUSH));
    assign bus.imem_addr   = req_addr;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instruction = instruction_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.pc_plus4    = pc_out_q + PC_INCR;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: sequential fetch, decode
// stall, redirects with and without ack, PC wrap and reset during FLUSH.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ready = 1'b0;
        step();
        step();
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", bus.imem_req); else n_pass++;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", bus.instruction); else n_pass++;
        n_checks++; if (bus.pc_out !== 32'h0) $display("FAIL rst_pc_out: got %h want 0", bus.pc_out); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.imem_addr); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL rel_req: got %0b want 1", bus.imem_req); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL rel_addr: got %h want 0", bus.imem_addr); else n_pass++;
    endtask

    // Memory acks during each request cycle, decode always ready.
    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'(i * 4);
            d = 32'hA000_0000 + 32'(i);
            n_checks++; if (bus.imem_addr !== a || bus.imem_req !== 1'b1) $display("FAIL seq_addr[%0d]: got %h req %0b want %h req 1", i, bus.imem_addr, bus.imem_req, a); else n_pass++;
            n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL seq_valid_lo[%0d]: got %0b want 0", i, bus.instr_valid); else n_pass++;
            bus.imem_ack = 1'b1;
            bus.imem_rdata = d;
            step();
            bus.imem_ack = 1'b0;
            bus.instr_ready = 1'b1;
            n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL seq_valid_hi[%0d]: got %0b want 1", i, bus.instr_valid); else n_pass++;
            n_checks++; if (bus.pc_out !== a) $display("FAIL seq_pc_out[%0d]: got %h want %h", i, bus.pc_out, a); else n_pass++;
            n_checks++; if (bus.instruction !== d) $display("FAIL seq_instr[%0d]: got %h want %h", i, bus.instruction, d); else n_pass++;
            n_checks++; if (bus.pc_plus4 !== a + 32'd4) $display("FAIL seq_pc_plus4[%0d]: got %h want %h", i, bus.pc_plus4, a + 32'd4); else n_pass++;
            n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL seq_req_hold[%0d]: got %0b want 0", i, bus.imem_req); else n_pass++;
            step();
            bus.instr_ready = 1'b0;
        end
    endtask

    task automatic test_stall();
        n_checks++; if (bus.imem_addr !== 32'd12) $display("FAIL stall_addr: got %h want c", bus.imem_addr); else n_pass++;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        step();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) $display("FAIL stall_hs[%0d]: got valid %0b req %0b want valid 1 req 0", i, bus.instr_valid, bus.imem_req); else n_pass++;
            n_checks++; if (bus.instruction !== 32'h1234_5678 || bus.pc_out !== 32'd12) $display("FAIL stall_data[%0d]: got %h @%h want 12345678 @c", i, bus.instruction, bus.pc_out); else n_pass++;
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'd16) $display("FAIL stall_release: got valid %0b addr %h want valid 0 addr 10", bus.instr_valid, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_flush();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.imem_addr !== 32'd16 || bus.imem_req !== 1'b1) $display("FAIL flush_outstanding[%0d]: got %h req %0b want 10 req 1", i, bus.imem_addr, bus.imem_req); else n_pass++;
            n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL flush_valid[%0d]: got %0b want 0", i, bus.instr_valid); else n_pass++;
            step();
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h0000_0100 || bus.instr_valid !== 1'b0) $display("FAIL flush_target: got %h valid %0b want 100 valid 0", bus.imem_addr, bus.instr_valid); else n_pass++;
        n_checks++; if (bus.instruction !== 32'h1234_5678) $display("FAIL flush_drop: got %h want 12345678", bus.instruction); else n_pass++;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        step();
        bus.imem_ack = 1'b0;
        n_checks++; if (bus.pc_out !== 32'h100 || bus.instruction !== 32'h13 || bus.instr_valid !== 1'b1) $display("FAIL flush_refetch: got %h @%h valid %0b want 13 @100 valid 1", bus.instruction, bus.pc_out, bus.instr_valid); else n_pass++;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h104) $display("FAIL flush_next: got %h want 104", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_with_ack();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_0000;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_2000;
        step();
        bus.imem_ack = 1'b0;
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL rda_valid: got %0b want 0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h2000 || bus.imem_req !== 1'b1) $display("FAIL rda_addr: got %h req %0b want 2000 req 1", bus.imem_addr, bus.imem_req); else n_pass++;
        n_checks++; if (bus.instruction !== 32'h13 || bus.pc_out !== 32'h100) $display("FAIL rda_keep: got %h @%h want 13 @100", bus.instruction, bus.pc_out); else n_pass++;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0000_2013;
        step();
        bus.imem_ack = 1'b0;
        n_checks++; if (bus.pc_out !== 32'h2000 || bus.instr_valid !== 1'b1) $display("FAIL rda_fetch: got @%h valid %0b want @2000 valid 1", bus.pc_out, bus.instr_valid); else n_pass++;
        // Redirect in HOLD overrides a simultaneous accept; low bits are dropped.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        bus.instr_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL hold_redirect: got valid %0b addr %h want valid 0 addr fffffffc", bus.instr_valid, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0000_1111;
        step();
        bus.imem_ack = 1'b0;
        n_checks++; if (bus.pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_out: got %h want fffffffc", bus.pc_out); else n_pass++;
        n_checks++; if (bus.pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want 0", bus.pc_plus4); else n_pass++;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 0", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0000_2222;
        step();
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h4) $display("FAIL rmf_pre_addr: got %h want 4", bus.imem_addr); else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h4 || bus.imem_req !== 1'b1) $display("FAIL rmf_flush: got %h req %0b want 4 req 1", bus.imem_addr, bus.imem_req); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) $display("FAIL rmf_async_hs: got req %0b valid %0b want 0 0", bus.imem_req, bus.instr_valid); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h0 || bus.pc_out !== 32'h0 || bus.instruction !== 32'h0) $display("FAIL rmf_async_regs: got addr %h pc_out %h instr %h want 0 0 0", bus.imem_addr, bus.pc_out, bus.instruction); else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) $display("FAIL rmf_release: got %h req %0b want 0 req 1", bus.imem_addr, bus.imem_req); else n_pass++;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0000_3333;
        step();
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b1;
        n_checks++; if (bus.pc_out !== 32'h0 || bus.instruction !== 32'h3333) $display("FAIL rmf_first: got %h @%h want 3333 @0", bus.instruction, bus.pc_out); else n_pass++;
        step();
        bus.instr_ready = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h4) $display("FAIL rmf_pc_reset: got %h want 4", bus.imem_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_redirect_with_ack();
        test_wrap();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
